// File: rtl/alu_exec_unit.sv
// rtl/alu_exec_unit.sv - execute-stage ALU with valid/ready handshakes and serial shifter
//
// Purpose: executes one ALU op per accepted request. Simple ops register their result
// in one cycle; SLL/SRL/SRA step one bit per cycle unless ALU_BARREL_SHIFT_EN is
// defined, in which case shifts are single-cycle as well.
//
// Configuration macro: ALU_BARREL_SHIFT_EN (undefined = serial shifter)
//
// Ports:
//   clk, rst (async, active-low), flush (sync kill of in-flight/held op)
//   in_valid/in_ready   request handshake carrying ALUControl, SrcA, SrcB, PC
//   out_valid/out_ready result handshake carrying Result, Zero, Negative
//   Busy                high while a serial shift is in progress
module alu_exec_unit #(
   parameter int WIDTH   = 32,
   parameter int SHAMT_W = 5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       ALUControl,
   input  logic [WIDTH-1:0] SrcA,
   input  logic [WIDTH-1:0] SrcB,
   input  logic [WIDTH-1:0] PC,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] Result,
   output logic             Zero,
   output logic             Negative,
   output logic             Busy
);

   localparam logic [3:0] OP_ADD   = 4'b0000;
   localparam logic [3:0] OP_SUB   = 4'b0001;
   localparam logic [3:0] OP_AND   = 4'b0010;
   localparam logic [3:0] OP_OR    = 4'b0011;
   localparam logic [3:0] OP_XOR   = 4'b0100;
   localparam logic [3:0] OP_SLT   = 4'b0101;
   localparam logic [3:0] OP_SLTU  = 4'b0110;
   localparam logic [3:0] OP_SLL   = 4'b0111;
   localparam logic [3:0] OP_SRL   = 4'b1000;
   localparam logic [3:0] OP_SRA   = 4'b1001;
   localparam logic [3:0] OP_AUIPC = 4'b1110;
   localparam logic [3:0] OP_LUI   = 4'b1111;

   localparam logic [1:0] K_SLL = 2'd0;
   localparam logic [1:0] K_SRL = 2'd1;
   localparam logic [1:0] K_SRA = 2'd2;

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   state_t               state_q, state_d;
   logic [WIDTH-1:0]     result_q;
   logic [WIDTH-1:0]     shreg_q;
   logic [WIDTH-1:0]     shift_next;
   logic [WIDTH-1:0]     alu_y;
   logic [SHAMT_W-1:0]   cnt_q;
   logic [SHAMT_W-1:0]   shamt;
   logic [1:0]           kind_q;
   logic                 fill_q;
   logic                 accept;
   logic                 is_shift;
   logic                 go_shift;
   logic                 last_step;

   assign shamt     = SrcB[SHAMT_W-1:0];
   assign is_shift  = (ALUControl == OP_SLL) || (ALUControl == OP_SRL) || (ALUControl == OP_SRA);
   assign last_step = (cnt_q == SHAMT_W'(1));
   assign accept    = in_valid && in_ready;

`ifdef ALU_BARREL_SHIFT_EN
   assign go_shift = 1'b0;
`else
   // A zero-amount shift is just SrcA, so it takes the single-cycle path.
   assign go_shift = is_shift && (shamt != '0);
`endif

   // Single-cycle result. In the serial build the shift cases only ever see N=0.
   always_comb begin
      alu_y = '0;
      case (ALUControl)
         OP_ADD:   alu_y = SrcA + SrcB;
         OP_SUB:   alu_y = SrcA - SrcB;
         OP_AND:   alu_y = SrcA & SrcB;
         OP_OR:    alu_y = SrcA | SrcB;
         OP_XOR:   alu_y = SrcA ^ SrcB;
         OP_SLT:   alu_y[0] = ($signed(SrcA) < $signed(SrcB));
         OP_SLTU:  alu_y[0] = (SrcA < SrcB);
`ifdef ALU_BARREL_SHIFT_EN
         OP_SLL:   alu_y = SrcA << shamt;
         OP_SRL:   alu_y = SrcA >> shamt;
         OP_SRA:   alu_y = $signed(SrcA) >>> shamt;
`else
         OP_SLL:   alu_y = SrcA;
         OP_SRL:   alu_y = SrcA;
         OP_SRA:   alu_y = SrcA;
`endif
         OP_AUIPC: alu_y = PC + SrcB;
         OP_LUI:   alu_y = SrcB;
         default:  alu_y = '0;
      endcase
   end

   // One serial step; SRA refills with the sign bit captured at accept.
   always_comb begin
      shift_next = '0;
      case (kind_q)
         K_SLL:   shift_next = {shreg_q[WIDTH-2:0], 1'b0};
         K_SRL:   shift_next = {1'b0, shreg_q[WIDTH-1:1]};
         default: shift_next = {fill_q, shreg_q[WIDTH-1:1]};
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      Busy      = 1'b0;
      case (state_q)
         IDLE: begin
            in_ready = !flush;
            if (in_valid && !flush) state_d = go_shift ? SHIFT : DONE;
         end
         SHIFT: begin
`ifndef ALU_BARREL_SHIFT_EN
            Busy = 1'b1;
`endif
            if (last_step) state_d = DONE;
         end
         DONE: begin
            out_valid = 1'b1;
            in_ready  = !flush && out_ready;
            if (in_valid && in_ready) state_d = go_shift ? SHIFT : DONE;
            else if (out_ready)       state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      if (flush) state_d = IDLE;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         result_q <= '0;
         shreg_q  <= '0;
         cnt_q    <= '0;
         kind_q   <= K_SLL;
         fill_q   <= 1'b0;
      end else if (flush) begin
         cnt_q <= '0;
      end else if (accept) begin
         if (go_shift) begin
            shreg_q <= SrcA;
            cnt_q   <= shamt;
            fill_q  <= SrcA[WIDTH-1];
            if (ALUControl == OP_SLL)      kind_q <= K_SLL;
            else if (ALUControl == OP_SRL) kind_q <= K_SRL;
            else                           kind_q <= K_SRA;
         end else begin
            result_q <= alu_y;
            cnt_q    <= '0;
         end
      end else if (state_q == SHIFT) begin
         shreg_q <= shift_next;
         cnt_q   <= cnt_q - SHAMT_W'(1);
         // Result is only touched by the final step so a flush leaves the old value.
         if (last_step) result_q <= shift_next;
      end
   end

   assign Result   = result_q;
   assign Zero     = (result_q == '0);
   assign Negative = result_q[WIDTH-1];

endmodule

// File: tb/tb_alu_exec_unit.sv
// tb/tb_alu_exec_unit.sv - self-checking bench for alu_exec_unit
module tb_alu_exec_unit;

`ifdef ALU_BARREL_SHIFT_EN
   localparam int SER = 0;
`else
   localparam int SER = 1;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic        flush;
   logic        in_valid;
   logic        in_ready;
   logic [3:0]  ALUControl;
   logic [31:0] SrcA, SrcB, PC;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] Result;
   logic        Zero, Negative, Busy;

   int n_cmp = 0;
   int n_bad = 0;

   alu_exec_unit #(.WIDTH(32), .SHAMT_W(5)) dut (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready),
      .ALUControl(ALUControl), .SrcA(SrcA), .SrcB(SrcB), .PC(PC),
      .out_valid(out_valid), .out_ready(out_ready),
      .Result(Result), .Zero(Zero), .Negative(Negative), .Busy(Busy)
   );

   always #5 clk = ~clk;

   task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic chk1(input string name, input logic act, input logic exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
      end
   endtask

   // Reference semantics of each op code.
   function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a,
                                           input logic [31:0] b, input logic [31:0] pc);
      int n;
      n = int'(b[4:0]);
      case (op)
         4'd0:  return a + b;
         4'd1:  return a - b;
         4'd2:  return a & b;
         4'd3:  return a | b;
         4'd4:  return a ^ b;
         4'd5:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         4'd6:  return (a < b) ? 32'd1 : 32'd0;
         4'd7:  return a << n;
         4'd8:  return a >> n;
         4'd9:  return 32'($signed(a) >>> n);
         4'd14: return pc + b;
         4'd15: return b;
         default: return 32'd0;
      endcase
   endfunction

   // Extra cycles an op spends before its result appears.
   function automatic int ref_extra(input logic [3:0] op, input logic [31:0] b);
      if (SER != 0 && (op == 4'd7 || op == 4'd8 || op == 4'd9)) return int'(b[4:0]);
      return 0;
   endfunction

   // Transaction-level model: one pending result, ready at a known cycle.
   int          cyc = 0;
   bit          m_pend = 0;
   logic [31:0] m_res = '0;
   int          m_ready_at = 0;

   initial begin
      bit done_now, exp_ir;
      forever begin
         @(negedge clk);
         cyc++;
         if (!rst) begin
            chk1("rst_out_valid", out_valid, 1'b0);
            chk1("rst_busy", Busy, 1'b0);
            chk32("rst_result", Result, 32'd0);
            m_pend = 0;
         end else begin
            done_now = m_pend && (cyc >= m_ready_at);
            exp_ir   = !flush && (!m_pend || (done_now && out_ready));
            chk1("m_in_ready", in_ready, exp_ir);
            chk1("m_out_valid", out_valid, done_now);
            chk1("m_busy", Busy, m_pend && !done_now);
            if (done_now) begin
               chk32("m_result", Result, m_res);
               chk1("m_zero", Zero, m_res == 32'd0);
               chk1("m_negative", Negative, m_res[31]);
            end
            if (flush) begin
               m_pend = 0;
            end else if (in_valid && exp_ir) begin
               m_pend     = 1;
               m_res      = ref_alu(ALUControl, SrcA, SrcB, PC);
               m_ready_at = cyc + 1 + ref_extra(ALUControl, SrcB);
            end else if (done_now && out_ready) begin
               m_pend = 0;
            end
         end
      end
   end

   task automatic do_op(input string name, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] pc,
                        input logic [31:0] exp_res, input int exp_lat, output int busy_n);
      int lat;
      busy_n = 0;
      @(posedge clk); #1;
      ALUControl = op; SrcA = a; SrcB = b; PC = pc; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      lat = 1;
      while (!out_valid && lat < 40) begin
         if (Busy) busy_n++;
         @(posedge clk); #1;
         lat++;
      end
      chk1({name, "_valid"}, out_valid, 1'b1);
      chk32({name, "_lat"}, 32'(lat), 32'(exp_lat));
      chk32({name, "_res"}, Result, exp_res);
   endtask

   initial begin
      int bn;
      int seen;
      rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      ALUControl = 4'd0; SrcA = '0; SrcB = '0; PC = '0;

      repeat (2) @(posedge clk);
      #1;
      chk1("reset_out_valid", out_valid, 1'b0);
      chk1("reset_busy", Busy, 1'b0);
      chk32("reset_result", Result, 32'd0);
      rst = 1'b1;
      #1;
      chk1("reset_in_ready", in_ready, 1'b1);

      do_op("add", 4'd0, 32'd5, 32'd7, 32'd0, 32'd12, 1, bn);
      chk1("add_zero", Zero, 1'b0);
      do_op("sub", 4'd1, 32'h1234, 32'h1234, 32'd0, 32'd0, 1, bn);
      chk1("sub_zero", Zero, 1'b1);
      do_op("slt", 4'd5, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'd1, 1, bn);
      do_op("sltu", 4'd6, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'd0, 1, bn);
      do_op("and", 4'd2, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'd0, 32'h00F0_00F0, 1, bn);
      do_op("or",  4'd3, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'd0, 32'hFFF0_FFF0, 1, bn);
      do_op("xor", 4'd4, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'd0, 32'hFF00_FF00, 1, bn);
      do_op("add_wrap", 4'd0, 32'hFFFF_FFFF, 32'd2, 32'd0, 32'd1, 1, bn);
      do_op("undef", 4'b1011, 32'h1111_1111, 32'h2222_2222, 32'd0, 32'd0, 1, bn);

      do_op("sra4", 4'd9, 32'h8000_0000, 32'd4, 32'd0, 32'hF800_0000, SER ? 5 : 1, bn);
      chk32("sra4_busy_cycles", 32'(bn), SER ? 32'd4 : 32'd0);
      chk1("sra4_negative", Negative, 1'b1);
      do_op("sll0", 4'd7, 32'h1234_5678, 32'd0, 32'd0, 32'h1234_5678, 1, bn);
      do_op("srl31", 4'd8, 32'h8000_0000, 32'd31, 32'd0, 32'd1, SER ? 32 : 1, bn);
      do_op("sll31", 4'd7, 32'h0000_0003, 32'd31, 32'd0, 32'h8000_0000, SER ? 32 : 1, bn);
      do_op("sra_pos", 4'd9, 32'h4000_0000, 32'd3, 32'd0, 32'h0800_0000, SER ? 4 : 1, bn);
      do_op("sra_mask", 4'd9, 32'h8000_0001, 32'hFFFF_FFE1, 32'd0, 32'hC000_0000, SER ? 2 : 1, bn);

      // Backpressure, then a back-to-back accept on the release edge.
      @(posedge clk); #1;
      out_ready = 1'b0;
      ALUControl = 4'd14; PC = 32'h100; SrcB = 32'h2000; SrcA = 32'd0; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      chk1("auipc_valid", out_valid, 1'b1);
      chk32("auipc_res", Result, 32'h2100);
      ALUControl = 4'd0; SrcA = 32'hDEAD_BEEF; SrcB = 32'h5555_5555; PC = 32'h0;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         chk32("hold_res", Result, 32'h2100);
         chk1("hold_valid", out_valid, 1'b1);
         chk1("hold_in_ready", in_ready, 1'b0);
      end
      ALUControl = 4'd15; SrcB = 32'hABCD_E000; in_valid = 1'b1; out_ready = 1'b1;
      #1;
      chk1("b2b_in_ready", in_ready, 1'b1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      chk1("lui_valid", out_valid, 1'b1);
      chk32("lui_res", Result, 32'hABCD_E000);

`ifndef ALU_BARREL_SHIFT_EN
      // Flush on the third SHIFT cycle.
      @(posedge clk); #1;
      ALUControl = 4'd7; SrcA = 32'd1; SrcB = 32'd20; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      chk1("flush_busy1", Busy, 1'b1);
      @(posedge clk); #1;
      @(posedge clk); #1;
      flush = 1'b1;
      chk1("flush_in_ready_low", in_ready, 1'b0);
      @(posedge clk); #1;
      flush = 1'b0;
      chk1("flush_out_valid", out_valid, 1'b0);
      chk1("flush_busy", Busy, 1'b0);
      chk32("flush_result_kept", Result, 32'hABCD_E000);
      #1;
      chk1("flush_in_ready", in_ready, 1'b1);
      seen = 0;
      for (int i = 0; i < 25; i++) begin
         @(posedge clk); #1;
         if (out_valid) seen++;
      end
      chk32("flush_no_valid", 32'(seen), 32'd0);

      // Asynchronous reset in the middle of a shift.
      @(posedge clk); #1;
      ALUControl = 4'd8; SrcA = 32'hFFFF_FFFF; SrcB = 32'd31; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      chk1("midrst_busy_before", Busy, 1'b1);
      #2;
      rst = 1'b0;
      #1;
      chk1("midrst_out_valid", out_valid, 1'b0);
      chk32("midrst_result", Result, 32'd0);
      chk1("midrst_busy", Busy, 1'b0);
      @(posedge clk); #1;
      rst = 1'b1;
      #1;
      chk1("midrst_in_ready", in_ready, 1'b1);
`endif
      do_op("add_after", 4'd0, 32'd1, 32'd1, 32'd0, 32'd2, 1, bn);

      repeat (3) @(posedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
